// File: rtl/fir_tap_loader.sv
// -----------------------------------------------------------------------------
// fir_tap_loader
//
// Double-buffered FIR coefficient loader. Coefficients stream in over a
// valid/ready handshake (tap 0 first) into a shadow bank. After the last tap
// is accepted, a one-cycle COMMIT state copies the whole shadow bank into the
// active bank in a single edge, so the filter never sees a half-loaded set.
//
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   load_start  in   begin (or restart) a coefficient load
//   load_abort  in   cancel an in-progress load
//   coef_valid  in   upstream has a coefficient on coef_data
//   coef_data   in   signed coefficient, TAP_WIDTH bits
//   coef_ready  out  loader accepts coef_data this cycle (LOAD only)
//   taps_flat   out  active bank, tap k at [k*TAP_WIDTH +: TAP_WIDTH]
//   rd_addr     in   read-back tap index
//   rd_data     out  active tap at rd_addr (combinational, 0 if out of range)
//   busy        out  high in LOAD or COMMIT
//   done        out  one-cycle pulse after the active bank was updated
//   coef_index  out  coefficients accepted in the current load
// -----------------------------------------------------------------------------
module fir_tap_loader #(
  parameter int TAP_WIDTH = 32,
  parameter int TAP_COUNT = 102
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           load_start,
  input  logic                           load_abort,
  input  logic                           coef_valid,
  input  logic [TAP_WIDTH-1:0]           coef_data,
  output logic                           coef_ready,
  output logic [TAP_COUNT*TAP_WIDTH-1:0] taps_flat,
  input  logic [$clog2(TAP_COUNT)-1:0]   rd_addr,
  output logic [TAP_WIDTH-1:0]           rd_data,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(TAP_COUNT+1)-1:0] coef_index
);

  localparam int ADDR_W = $clog2(TAP_COUNT);
  localparam int IDX_W  = $clog2(TAP_COUNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     coef_index_q, coef_index_d;
  logic                 done_q, done_d;
  logic [TAP_WIDTH-1:0] shadow_q [TAP_COUNT];
  logic [TAP_WIDTH-1:0] shadow_d [TAP_COUNT];
  logic [TAP_WIDTH-1:0] active_q [TAP_COUNT];
  logic [TAP_WIDTH-1:0] active_d [TAP_COUNT];

  logic                 shadow_we_s;
  logic                 commit_s;
  logic                 coef_ready_s;
  logic                 busy_s;
  logic [ADDR_W-1:0]    wr_addr_s;

  // In LOAD the counter is always below TAP_COUNT, so its low bits are a legal tap address.
  assign wr_addr_s = coef_index_q[ADDR_W-1:0];

  // Next-state, counter and control decode for the load FSM.
  always_comb begin
    state_d      = state_q;
    coef_index_d = coef_index_q;
    shadow_we_s  = 1'b0;
    commit_s     = 1'b0;
    done_d       = 1'b0;
    coef_ready_s = 1'b0;
    busy_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // load_abort has no meaning here and is ignored.
        if (load_start) begin
          state_d      = ST_LOAD;
          coef_index_d = {IDX_W{1'b0}};
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_LOAD: begin
        coef_ready_s = 1'b1;
        busy_s       = 1'b1;
        // Priority: abort, then restart, then the handshake; the first two drop any beat.
        if (load_abort) begin
          state_d      = ST_IDLE;
          coef_index_d = {IDX_W{1'b0}};
        end else if (load_start) begin
          state_d      = ST_LOAD;
          coef_index_d = {IDX_W{1'b0}};
        end else if (coef_valid) begin
          shadow_we_s  = 1'b1;
          coef_index_d = coef_index_q + {{(IDX_W-1){1'b0}}, 1'b1};
          if (coef_index_q == IDX_W'(TAP_COUNT - 1)) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_COMMIT: begin
        // Start/abort are not looked at: a commit always completes.
        busy_s   = 1'b1;
        commit_s = 1'b1;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d      = ST_IDLE;
        coef_index_d = {IDX_W{1'b0}};
      end
    endcase
  end

  // Shadow bank write and whole-bank copy into the active bank.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (shadow_we_s) begin
      shadow_d[wr_addr_s] = coef_data;
    end else begin
      shadow_d = shadow_q;
    end
    if (commit_s) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end
  end

  // State, counter, done pulse and both coefficient banks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      coef_index_q <= {IDX_W{1'b0}};
      done_q       <= 1'b0;
      for (int k = 0; k < TAP_COUNT; k++) begin
        shadow_q[k] <= {TAP_WIDTH{1'b0}};
        active_q[k] <= {TAP_WIDTH{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      coef_index_q <= coef_index_d;
      done_q       <= done_d;
      for (int k = 0; k < TAP_COUNT; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
    end
  end

  // Flatten the active bank onto the output bus.
  always_comb begin
    taps_flat = {(TAP_COUNT*TAP_WIDTH){1'b0}};
    for (int k = 0; k < TAP_COUNT; k++) begin
      taps_flat[k*TAP_WIDTH +: TAP_WIDTH] = active_q[k];
    end
  end

  // Read-back mux; addresses past the last tap read as zero.
  always_comb begin
    rd_data = {TAP_WIDTH{1'b0}};
    if (int'(rd_addr) < TAP_COUNT) begin
      rd_data = active_q[rd_addr];
    end else begin
      rd_data = {TAP_WIDTH{1'b0}};
    end
  end

  assign coef_ready = coef_ready_s;
  assign busy       = busy_s;
  assign done       = done_q;
  assign coef_index = coef_index_q;

endmodule
